onehot_sweep_driver: RTL and testbench
======================================

Name: onehot_sweep_driver

Overview:
- Synchronous stimulus and response end of the 4-bit "exactly-one-hot" checker interface (En, W[3:0] -> f).
- Drives En/W through all 16 codes, holds each code for a fixed number of settle cycles, samples the checker's f and compares it against an internal golden function.
- Reports the mismatch count, the first failing code, and a pass flag.
- Used on-chip, or as a synthesizable self-check harness in front of the combinational checker.

Parameters:
- HOLD, 4, cycles each code is driven before f is sampled; legal range 2..255.
- CNT_W, 8, width of the internal hold counter; must hold HOLD-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a sweep
- en_mode  input  1  value driven on En for the whole sweep; latched at start
- f_in  input  1  checker output f
- En  output  1  enable to checker
- W  output  4  code to checker
- busy  output  1  sweep in progress
- done  output  1  sweep finished; level, held until next accepted start or rst
- pass  output  1  done AND err_count==0
- err_count  output  5  number of mismatching codes, 0..16
- first_fail_valid  output  1  at least one mismatch seen in the current sweep
- first_fail_code  output  4  W value of the first mismatch

Behaviour:
- Reset values, applied on any clk edge with rst=1 including mid-sweep:
  - state=IDLE.
  - En=0, W=0, busy=0, done=0, pass=0.
  - err_count=0, first_fail_valid=0, first_fail_code=0.
  - hold counter=0.
- Golden function: f_exp = En & (W has exactly one bit set). f_exp=1 only for W in {1,2,4,8} with En=1.
- FSM states:
  - IDLE: start=1 -> DRIVE. Latch en_mode into En, set W=0 and hold_cnt=0, clear err_count/first_fail_*, busy=1.
  - DRIVE: each cycle hold_cnt increments.
    - At hold_cnt==HOLD-1: register cmp = (f_in != f_exp), computed from the W/En currently driven.
    - On mismatch: err_count+1. If first_fail_valid=0, set first_fail_valid=1 and first_fail_code=W.
    - Then hold_cnt=0. If W!=15, W=W+1. If W==15 -> DONE. W stays 15; no wrap.
  - DONE: busy=0, done=1, pass=(err_count==0). En and W keep their last values.
    - start=1 -> DRIVE with the same init as from IDLE; done and pass clear on that edge.
- Timing: start accepted at edge E0. busy=1 after E0 through edge E(16*HOLD). done=1 after E(16*HOLD). Each W value is stable for exactly HOLD cycles.
- f_in is sampled only at the last hold cycle. Glitches at earlier hold cycles are ignored.
- start while busy=1 is ignored; no restart and no effect on counts.
- start and rst in the same cycle: rst wins.
- en_mode changes during a sweep have no effect.
- err_count cannot exceed 16, so it needs no saturation logic.
- All outputs are registered; no combinational path from f_in to any output.

Test Plan:
- HOLD=4, en_mode=1, golden checker on f_in, start pulse.
  - busy for 64 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0.
  - W steps 0..15, each value held 4 cycles.
- en_mode=1, f_in tied 0 -> err_count=4, first_fail_code=1, pass=0, done=1 after 64 cycles.
- en_mode=1, f_in tied 1 -> err_count=12, first_fail_code=0, pass=0.
- en_mode=0, golden checker (f=0 throughout) -> En=0 for the whole sweep, err_count=0, pass=1.
- en_mode=0, f_in tied 1 -> err_count=16, first_fail_code=0.
- start pulse at W=5 while busy -> sweep is unaffected and err_count is unchanged.
- rst at W=7 -> next cycle all outputs at reset values. A new start then runs a full 64-cycle sweep from W=0 with correct results.
- start in DONE after a failing sweep -> err_count, first_fail_* and done clear on the accepting edge. A golden rerun then ends with pass=1.

Source files
------------

// File: rtl/onehot_sweep_driver.sv
// Sweeps all 16 En/W codes into a 4-bit exactly-one-hot checker, samples its f output
// at the end of each hold window and tallies mismatches against the golden function.
module onehot_sweep_driver #(
    parameter int HOLD  = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       en_mode,
    input  logic       f_in,
    output logic       En,
    output logic [3:0] W,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       first_fail_valid,
    output logic [3:0] first_fail_code
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);

    state_t           state_q, state_d;
    logic             en_q, en_d;
    logic [3:0]       w_q, w_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [4:0]       err_q, err_d;
    logic             ffv_q, ffv_d;
    logic [3:0]       ffc_q, ffc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fExp;
    logic             mismatch;

    assign fExp     = en_q & (w_q != 4'd0) & ((w_q & (w_q - 4'd1)) == 4'd0);
    assign mismatch = (f_in != fExp);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            w_q     <= 4'd0;
            hold_q  <= '0;
            err_q   <= 5'd0;
            ffv_q   <= 1'b0;
            ffc_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            w_q     <= w_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffc_q   <= ffc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // f_in only matters on the last cycle of each hold window; earlier cycles let it settle.
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        w_d     = w_q;
        hold_d  = hold_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffc_d   = ffc_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    en_d    = en_mode;
                    w_d     = 4'd0;
                    hold_d  = '0;
                    err_d   = 5'd0;
                    ffv_d   = 1'b0;
                    ffc_d   = 4'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (mismatch) begin
                        err_d = err_q + 5'd1;
                        if (!ffv_q) begin
                            ffv_d = 1'b1;
                            ffc_d = w_q;
                        end
                    end
                    if (w_q == 4'd15) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 5'd0);
                    end else begin
                        w_d = w_q + 4'd1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign En               = en_q;
    assign W                = w_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_code  = ffc_q;

endmodule

// File: tb/tb_onehot_sweep_driver.sv
// Directed bench for onehot_sweep_driver: table of full sweeps against a golden or
// stuck checker, plus hand sequences for busy-restart, mid-sweep reset and rerun.
module tb_onehot_sweep_driver;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       en_mode;
    logic       f_in;
    logic       En;
    logic [3:0] W;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic       first_fail_valid;
    logic [3:0] first_fail_code;

    // 0 = golden checker, 1 = f stuck at 0, 2 = f stuck at 1
    int fMode;
    int errors;
    int checks;

    typedef struct {
        logic en;
        int   fm;
        int   pokeW;
        int   expErr;
        logic expFfv;
        int   expFfc;
        logic expPass;
    } vec_t;

    vec_t vecs[7];

    onehot_sweep_driver #(.HOLD(HOLD), .CNT_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .en_mode          (en_mode),
        .f_in             (f_in),
        .En               (En),
        .W                (W),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_code  (first_fail_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        f_in = 1'b0;
        case (fMode)
            0: f_in = En & (W == 4'd1 || W == 4'd2 || W == 4'd4 || W == 4'd8);
            1: f_in = 1'b0;
            default: f_in = 1'b1;
        endcase
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".busy"}, int'(busy), 0);
        checkOutput({tag, ".done"}, int'(done), 0);
        checkOutput({tag, ".pass"}, int'(pass), 0);
        checkOutput({tag, ".En"}, int'(En), 0);
        checkOutput({tag, ".W"}, int'(W), 0);
        checkOutput({tag, ".err"}, int'(err_count), 0);
        checkOutput({tag, ".ffv"}, int'(first_fail_valid), 0);
        checkOutput({tag, ".ffc"}, int'(first_fail_code), 0);
    endtask

    // Starts a sweep and follows it to completion; optionally re-pulses start when W hits pokeW.
    task automatic applyStimulus(input vec_t v, input string tag);
        int cycles;
        int bad;
        bit poked;
        cycles = 0;
        bad    = 0;
        poked  = 1'b0;
        fMode  = v.fm;
        @(negedge clk);
        en_mode = v.en;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        en_mode = ~v.en;
        checkOutput({tag, ".startBusy"}, int'(busy), 1);
        checkOutput({tag, ".startDone"}, int'(done), 0);
        checkOutput({tag, ".startPass"}, int'(pass), 0);
        checkOutput({tag, ".startErr"}, int'(err_count), 0);
        checkOutput({tag, ".startFfv"}, int'(first_fail_valid), 0);
        checkOutput({tag, ".startFfc"}, int'(first_fail_code), 0);
        while (busy && cycles < 200) begin
            if (int'(W) != cycles / HOLD || En != v.en) bad++;
            start = 1'b0;
            if (v.pokeW >= 0 && int'(W) == v.pokeW && !poked) begin
                start = 1'b1;
                poked = 1'b1;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        checkOutput({tag, ".wSequence"}, bad, 0);
        checkOutput({tag, ".busyCycles"}, cycles, 16 * HOLD);
        checkOutput({tag, ".done"}, int'(done), 1);
        checkOutput({tag, ".pass"}, int'(pass), int'(v.expPass));
        checkOutput({tag, ".err"}, int'(err_count), v.expErr);
        checkOutput({tag, ".ffv"}, int'(first_fail_valid), int'(v.expFfv));
        if (v.expFfv) checkOutput({tag, ".ffc"}, int'(first_fail_code), v.expFfc);
        checkOutput({tag, ".finalW"}, int'(W), 15);
        checkOutput({tag, ".finalEn"}, int'(En), int'(v.en));
    endtask

    initial begin
        int waitCnt;
        vec_t g;
        errors  = 0;
        checks  = 0;
        fMode   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        en_mode = 1'b0;

        vecs[0] = '{en: 1'b1, fm: 0, pokeW: -1, expErr: 0,  expFfv: 1'b0, expFfc: 0, expPass: 1'b1};
        vecs[1] = '{en: 1'b1, fm: 1, pokeW: -1, expErr: 4,  expFfv: 1'b1, expFfc: 1, expPass: 1'b0};
        vecs[2] = '{en: 1'b1, fm: 2, pokeW: -1, expErr: 12, expFfv: 1'b1, expFfc: 0, expPass: 1'b0};
        vecs[3] = '{en: 1'b0, fm: 0, pokeW: -1, expErr: 0,  expFfv: 1'b0, expFfc: 0, expPass: 1'b1};
        vecs[4] = '{en: 1'b0, fm: 2, pokeW: -1, expErr: 16, expFfv: 1'b1, expFfc: 0, expPass: 1'b0};
        vecs[5] = '{en: 1'b1, fm: 0, pokeW: 5,  expErr: 0,  expFfv: 1'b0, expFfc: 0, expPass: 1'b1};
        vecs[6] = '{en: 1'b1, fm: 2, pokeW: 5,  expErr: 12, expFfv: 1'b1, expFfc: 0, expPass: 1'b0};

        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Mid-sweep reset with start asserted in the same cycle: reset must win.
        fMode = 2;
        @(negedge clk);
        en_mode = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        waitCnt = 0;
        while (W != 4'd7 && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("rstSeq.reachW7", int'(W), 7);
        checkOutput("rstSeq.errBefore", int'(err_count), 4);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checkResetState("rstSeq");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("rstSeq.stayIdle", int'(busy), 0);

        g = '{en: 1'b1, fm: 0, pokeW: -1, expErr: 0, expFfv: 1'b0, expFfc: 0, expPass: 1'b1};
        applyStimulus(g, "afterRst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
